// File: rtl/mu0_control_unit.sv
// ============================================================================
// mu0_control_unit : MU0 fetch/execute sequencer with wait states, watchdog,
//                    halt and retired-instruction counter.   Rev 1.0
// ============================================================================
`default_nettype none

module mu0_control_unit #(
  parameter int COUNT_W    = 16,
  parameter int WAIT_LIMIT = 15
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [3:0]         F,
  input  logic               N,
  input  logic               Z,
  input  logic               Mem_Ready,
  output logic               X_sel,
  output logic               Y_sel,
  output logic               Addr_sel,
  output logic               PC_En,
  output logic               IR_En,
  output logic               Acc_En,
  output logic [1:0]         M,
  output logic               Rd,
  output logic               Wr,
  output logic               Halted,
  output logic               Bus_Err,
  output logic [COUNT_W-1:0] Instr_Count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT);

  state_t               state_q, state_d;
  logic [7:0]           wait_q, wait_d;
  logic                 bus_err_q, bus_err_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic                 w_access;
  logic                 w_pc_en, w_ir_en, w_acc_en, w_rd, w_wr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      bus_err_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    X_sel     = 1'b0;
    Y_sel     = 1'b0;
    Addr_sel  = 1'b0;
    M         = 2'b00;
    Halted    = 1'b0;
    w_pc_en   = 1'b0;
    w_ir_en   = 1'b0;
    w_acc_en  = 1'b0;
    w_rd      = 1'b0;
    w_wr      = 1'b0;
    w_access  = 1'b0;
    state_d   = state_q;
    wait_d    = wait_q;
    bus_err_d = bus_err_q;
    count_d   = count_q;

    case (state_q)
      S_FETCH: begin
        w_access = 1'b1;
        w_rd     = 1'b1;
        X_sel    = 1'b1;
        M        = 2'b10;
        w_ir_en  = Mem_Ready;
        w_pc_en  = Mem_Ready;
      end
      S_EXEC: begin
        if (F[3:2] == 2'b00) begin
          w_access = 1'b1;
          Addr_sel = 1'b1;
          case (F[1:0])
            2'd0: begin
              w_rd     = 1'b1;
              w_acc_en = Mem_Ready;
            end
            2'd1: w_wr = 1'b1;
            2'd2: begin
              w_rd     = 1'b1;
              M        = 2'b01;
              w_acc_en = Mem_Ready;
            end
            default: begin
              w_rd     = 1'b1;
              M        = 2'b11;
              w_acc_en = Mem_Ready;
            end
          endcase
        end else begin
          // Single-cycle opcodes retire unconditionally, taken jump or not.
          case (F)
            4'h4: begin
              Y_sel   = 1'b1;
              w_pc_en = 1'b1;
            end
            4'h5: begin
              Y_sel   = 1'b1;
              w_pc_en = ~N;
            end
            4'h6: begin
              Y_sel   = 1'b1;
              w_pc_en = ~Z;
            end
            default: ;
          endcase
          state_d = (F == 4'h7) ? S_HALT : S_FETCH;
          wait_d  = 8'd0;
          count_d = count_q + 1'b1;
        end
      end
      S_HALT:  Halted = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // Completion wins over timeout when both land on the same cycle.
    if (w_access) begin
      if (Mem_Ready) begin
        wait_d = 8'd0;
        if (state_q == S_FETCH) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
          count_d = count_q + 1'b1;
        end
      end else if (wait_q == WAIT_MAX) begin
        state_d   = S_HALT;
        bus_err_d = 1'b1;
        wait_d    = 8'd0;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
  end

  assign PC_En       = w_pc_en  & ~Reset;
  assign IR_En       = w_ir_en  & ~Reset;
  assign Acc_En      = w_acc_en & ~Reset;
  assign Rd          = w_rd     & ~Reset;
  assign Wr          = w_wr     & ~Reset;
  assign Bus_Err     = bus_err_q;
  assign Instr_Count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_mu0_control_unit.sv
// ============================================================================
// tb_mu0_control_unit : scoreboard bench for the MU0 control unit, with a
//                       small MU0 datapath/memory driven by the DUT.  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mu0_control_unit;

  localparam int COUNT_W    = 16;
  localparam int WAIT_LIMIT = 15;

  logic               Clk = 1'b0;
  logic               Reset = 1'b1;
  logic [3:0]         F = 4'h0;
  logic               N = 1'b0;
  logic               Z = 1'b0;
  logic               Mem_Ready = 1'b0;
  logic               X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En;
  logic [1:0]         M;
  logic               Rd, Wr, Halted, Bus_Err;
  logic [COUNT_W-1:0] Instr_Count;

  always #5 Clk = ~Clk;

  mu0_control_unit #(.COUNT_W(COUNT_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_Ready(Mem_Ready),
    .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel), .PC_En(PC_En),
    .IR_En(IR_En), .Acc_En(Acc_En), .M(M), .Rd(Rd), .Wr(Wr),
    .Halted(Halted), .Bus_Err(Bus_Err), .Instr_Count(Instr_Count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [11:0] ctrl;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];

  // Reference model state: 0=FETCH 1=EXEC 2=HALT
  int          m_st;
  int          m_wait;
  logic [15:0] m_cnt;
  logic        m_err;

  // Datapath and memory
  logic [15:0] mem [0:4095];
  logic [11:0] dp_pc;
  logic [15:0] dp_acc, dp_ir;
  logic        wr_seen;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;

  function automatic logic [11:0] dut_ctrl();
    return {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, M, Rd, Wr, Halted, Bus_Err};
  endfunction

  // Bit order: xs ys as pce ire acce m[1:0] rd wr halted bus_err
  function automatic logic [11:0] exp_ctrl(input int st, input logic [3:0] f, input logic n,
                                           input logic z, input logic mr, input logic rst,
                                           input logic err);
    logic xs, ys, as, pce, ire, acce, rd, wr, hl;
    logic [1:0] m;
    {xs, ys, as, pce, ire, acce, rd, wr, hl} = '0;
    m = 2'b00;
    if (st == 0) begin
      rd = 1; xs = 1; m = 2'b10; ire = mr; pce = mr;
    end else if (st == 1) begin
      unique case (f)
        4'h0: begin as = 1; rd = 1; acce = mr; end
        4'h1: begin as = 1; wr = 1; end
        4'h2: begin as = 1; rd = 1; m = 2'b01; acce = mr; end
        4'h3: begin as = 1; rd = 1; m = 2'b11; acce = mr; end
        4'h4: begin ys = 1; pce = 1; end
        4'h5: begin ys = 1; pce = ~n; end
        4'h6: begin ys = 1; pce = ~z; end
        default: ;
      endcase
    end else begin
      hl = 1;
    end
    if (rst) begin
      pce = 0; ire = 0; acce = 0; rd = 0; wr = 0;
    end
    return {xs, ys, as, pce, ire, acce, m, rd, wr, hl, err};
  endfunction

  task automatic model_step(input logic rst, input logic [3:0] f, input logic mr);
    if (rst) begin
      m_st = 0; m_wait = 0; m_cnt = 16'd0; m_err = 1'b0;
    end else if (m_st == 0 || (m_st == 1 && f < 4'h4)) begin
      if (mr) begin
        if (m_st == 1) m_cnt = m_cnt + 16'd1;
        m_st   = (m_st == 0) ? 1 : 0;
        m_wait = 0;
      end else if (m_wait == WAIT_LIMIT) begin
        m_st = 2; m_err = 1'b1; m_wait = 0;
      end else begin
        m_wait++;
      end
    end else if (m_st == 1) begin
      m_st   = (f == 4'h7) ? 2 : 0;
      m_cnt  = m_cnt + 16'd1;
      m_wait = 0;
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] f, input logic n, input logic z,
                       input logic mr, input string tag);
    exp_t        e;
    logic [11:0] addr;
    logic [15:0] din, xv, yv, alu;
    logic        pce, ire, acce;
    Reset = rst; F = f; N = n; Z = z; Mem_Ready = mr;
    e.tag  = tag;
    e.ctrl = exp_ctrl(m_st, f, n, z, mr, rst, m_err);
    e.cnt  = m_cnt;
    sb.push_back(e);
    @(negedge Clk);
    e = sb.pop_front();
    check_val({e.tag, ".ctrl"}, 32'(dut_ctrl()), 32'(e.ctrl));
    check_val({e.tag, ".cnt"}, 32'(Instr_Count), 32'(e.cnt));
    addr = Addr_sel ? dp_ir[11:0] : dp_pc;
    din  = mem[addr];
    xv   = X_sel ? {4'h0, dp_pc} : dp_acc;
    yv   = Y_sel ? {4'h0, dp_ir[11:0]} : din;
    case (M)
      2'b00:   alu = yv;
      2'b01:   alu = xv + yv;
      2'b10:   alu = xv + 16'd1;
      default: alu = xv - yv;
    endcase
    pce = PC_En; ire = IR_En; acce = Acc_En;
    if (Wr && Mem_Ready) begin
      wr_seen = 1'b1; wr_addr = addr; wr_data = dp_acc;
    end
    @(posedge Clk);
    model_step(rst, f, mr);
    if (rst) begin
      dp_pc = 12'd0; dp_acc = 16'd0; dp_ir = 16'd0; wr_seen = 1'b0;
    end else begin
      if (ire)  dp_ir  = din;
      if (pce)  dp_pc  = alu[11:0];
      if (acce) dp_acc = alu;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'hA000;
    dp_pc = 12'd0; dp_acc = 16'd0; dp_ir = 16'd0;
    wr_seen = 1'b0; wr_addr = 12'd0; wr_data = 16'd0;
    m_st = 0; m_wait = 0; m_cnt = 16'd0; m_err = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    // Reset state: FETCH selects visible, every enable and strobe held low
    drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, "reset");

    // Zero-wait program: LDA 010, ADD 011, STA 012, STP
    mem[0] = 16'h0010; mem[1] = 16'h2011; mem[2] = 16'h1012; mem[3] = 16'h7000;
    mem[16'h10] = 16'h0005; mem[16'h11] = 16'h0003;
    drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, "prog_rst");
    for (int i = 0; i < 8; i++)
      drive(1'b0, dp_ir[15:12], dp_acc[15], dp_acc == 16'd0, 1'b1, "prog");
    check_val("prog_halted", 32'(Halted), 32'd1);
    check_val("prog_count", 32'(Instr_Count), 32'd4);
    check_val("prog_wr_seen", 32'(wr_seen), 32'd1);
    check_val("prog_wr_addr", 32'(wr_addr), 32'h012);
    check_val("prog_wr_data", 32'(wr_data), 32'h0008);

    // FETCH with three wait states, then a NOP execute
    mem[0] = 16'hA000;
    drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, "fw_rst");
    repeat (3) drive(1'b0, 4'hA, 1'b0, 1'b0, 1'b0, "fw_wait");
    drive(1'b0, 4'hA, 1'b0, 1'b0, 1'b1, "fw_go");
    check_val("fw_pc", 32'(dp_pc), 32'd1);
    check_val("fw_ir", 32'(dp_ir), 32'hA000);
    drive(1'b0, dp_ir[15:12], 1'b0, 1'b0, 1'b0, "nop");
    check_val("nop_count", 32'(Instr_Count), 32'd1);

    // Conditional jumps
    mem[0] = 16'h5123; mem[1] = 16'h5123; mem[16'h123] = 16'h6000;
    drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, "jmp_rst");
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "jmp_f1");
    drive(1'b0, 4'h5, 1'b1, 1'b0, 1'b1, "jge_n1");
    check_val("jge_n1_pc", 32'(dp_pc), 32'd1);
    drive(1'b0, 4'h5, 1'b0, 1'b0, 1'b1, "jmp_f2");
    drive(1'b0, 4'h5, 1'b0, 1'b0, 1'b0, "jge_n0");
    check_val("jge_n0_pc", 32'(dp_pc), 32'h123);
    drive(1'b0, 4'h5, 1'b0, 1'b0, 1'b1, "jmp_f3");
    drive(1'b0, 4'h6, 1'b0, 1'b1, 1'b1, "jne_z1");
    check_val("jne_z1_pc", 32'(dp_pc), 32'h124);
    check_val("jmp_count", 32'(Instr_Count), 32'd3);

    // STA wait-state timeout
    mem[0] = 16'h1012;
    drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, "to_rst");
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "to_fetch");
    repeat (16) drive(1'b0, 4'h1, 1'b0, 1'b0, 1'b0, "to_wait");
    check_val("to_halted", 32'(Halted), 32'd1);
    check_val("to_bus_err", 32'(Bus_Err), 32'd1);
    check_val("to_count", 32'(Instr_Count), 32'd0);
    check_val("to_no_wr", 32'(wr_seen), 32'd0);
    drive(1'b0, 4'h1, 1'b0, 1'b0, 1'b1, "halt_idle");
    drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, "halt_rst");
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, "after_halt");
    check_val("after_halt_err", 32'(Bus_Err), 32'd0);
    check_val("after_halt_hlt", 32'(Halted), 32'd0);

    // Completion exactly at the wait limit
    drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, "lim_rst");
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "lim_fetch");
    repeat (15) drive(1'b0, 4'h1, 1'b0, 1'b0, 1'b0, "lim_wait");
    drive(1'b0, 4'h1, 1'b0, 1'b0, 1'b1, "lim_done");
    check_val("lim_bus_err", 32'(Bus_Err), 32'd0);
    check_val("lim_halted", 32'(Halted), 32'd0);
    check_val("lim_count", 32'(Instr_Count), 32'd1);
    check_val("lim_wr_addr", 32'(wr_addr), 32'h012);

    // Reset during ADD execute abandons the access
    mem[0] = 16'h2011; mem[16'h11] = 16'h0003;
    drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, "add_rst0");
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "add_fetch");
    drive(1'b1, 4'h2, 1'b0, 1'b0, 1'b1, "add_rst");
    check_val("add_rst_acc", 32'(dp_acc), 32'd0);
    drive(1'b0, 4'h2, 1'b0, 1'b0, 1'b0, "post_rst");
    check_val("post_rst_count", 32'(Instr_Count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mu0_control_unit.md
Name: mu0_control_unit

Overview:
- Control unit that sequences the MU0 datapath through alternating fetch and execute cycles.
- Decodes F (IR[15:12]) together with the N/Z flags to drive every datapath mux select, register enable and ALU mode.
- Adds a memory wait-state handshake (Mem_Ready), a wait-timeout watchdog, a halt state and a retired-instruction counter.
- Sits between the MU0 datapath and the memory interface.

Parameters:
COUNT_W, 16, width of retired-instruction counter Instr_Count
WAIT_LIMIT, 15, max consecutive Mem_Ready=0 cycles tolerated in one memory access (1..255); exceeding it is a bus error

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
F  input  4  opcode from datapath (IR[15:12])
N  input  1  Acc negative flag
Z  input  1  Acc zero flag
Mem_Ready  input  1  memory completes current Rd/Wr this cycle when 1
X_sel  output  1  X mux select: 0=Acc, 1=PC
Y_sel  output  1  Y mux select: 0=Din, 1=IR
Addr_sel  output  1  address mux select: 0=PC, 1=IR[11:0]
PC_En  output  1  PC load enable
IR_En  output  1  IR load enable
Acc_En  output  1  Acc load enable
M  output  2  ALU mode: 00=Y, 01=X+Y, 10=X+1, 11=X-Y
Rd  output  1  memory read strobe
Wr  output  1  memory write strobe
Halted  output  1  1 while in HALT
Bus_Err  output  1  sticky; set on wait-timeout
Instr_Count  output  COUNT_W  instructions retired, wraps modulo 2^COUNT_W

Behaviour:
- States: FETCH, EXEC, HALT. Outputs are combinational from state, F, N, Z and Mem_Ready. Undriven selects are 0; M defaults to 00.
- Reset (sampled at edge):
  - Registered state: state=FETCH, Halted=0, Bus_Err=0, Instr_Count=0, wait counter=0.
  - While Reset=1, PC_En, IR_En, Acc_En, Rd and Wr are forced to 0 regardless of state.
  - Reset mid-access abandons the access; no enable fires.
- FETCH:
  - Drive Addr_sel=0, Rd=1, X_sel=1, M=10.
  - IR_En=PC_En=Mem_Ready.
  - Mem_Ready=1: go to EXEC. Else stay in FETCH and increment the wait counter.
- EXEC, memory opcodes (address IR[11:0], Addr_sel=1; the enable/strobe listed is qualified by Mem_Ready):
  - 0 LDA: Rd=1, Y_sel=0, M=00, Acc_En=Mem_Ready.
  - 1 STA: Wr=1, X_sel=0 (Acc drives Dout). The Wr level stays asserted through wait states; completion is Mem_Ready=1.
  - 2 ADD: Rd=1, X_sel=0, Y_sel=0, M=01, Acc_En=Mem_Ready.
  - 3 SUB: as ADD with M=11.
  - Completion (Mem_Ready=1): go to FETCH and increment Instr_Count. Else stay in EXEC and increment the wait counter.
- EXEC, single-cycle opcodes (Mem_Ready ignored, no Rd/Wr):
  - 4 JMP: Y_sel=1, M=00, PC_En=1.
  - 5 JGE: as JMP but PC_En=~N.
  - 6 JNE: as JMP but PC_En=~Z.
  - Each goes to FETCH and increments Instr_Count, whether or not the jump is taken.
  - 7 STP: no enables; go to HALT and increment Instr_Count.
  - 8..F: NOP; no enables; go to FETCH and increment Instr_Count.
- Wait counter:
  - Cleared on every state transition.
  - When the counter reaches WAIT_LIMIT and Mem_Ready is still 0, the next edge goes to HALT and sets Bus_Err=1. The aborted instruction is not counted.
- HALT:
  - All enables and strobes are 0; Halted=1.
  - Leaves only via Reset.
- Simultaneous events:
  - Reset overrides completion and timeout.
  - Mem_Ready=1 in the same cycle the wait counter reaches WAIT_LIMIT means completion, not error.
- Latency:
  - Zero-wait memory: every instruction takes 2 cycles.
  - Each wait state adds 1 cycle per access.

Test Plan:
- Zero-wait program LDA 0x010 (mem=0x0005), ADD 0x011 (0x0003), STA 0x012, STP -> Wr at address 0x012 with Dout=0x0008; Halted after 8 cycles; Instr_Count=4.
- FETCH with Mem_Ready low for 3 cycles, then high -> IR_En/PC_En asserted only in the 4th cycle; Rd held with Addr_sel=0 throughout; PC advances by exactly 1.
- JGE with N=1 -> PC_En=0 in EXEC. JGE with N=0, target 0x123 -> PC_En=1, Y_sel=1, M=00. JNE with Z=1 -> not taken. Instr_Count increments in all three cases.
- STA with Mem_Ready held 0 beyond WAIT_LIMIT=15 -> HALT after the 16th wait cycle edge; Bus_Err=1; Instr_Count unchanged. Same run with Mem_Ready=1 exactly at count 15 -> completes normally, Bus_Err=0.
- Opcode 0xA in EXEC -> no enables, no Rd/Wr; back to FETCH; Instr_Count+1.
- Reset asserted mid-EXEC of ADD with Mem_Ready=1 -> Acc_En=0 that cycle. Next cycle: FETCH, Instr_Count=0, Bus_Err=0. HALT plus Reset -> returns to FETCH.
